// File: rtl/accelerator_pkg.sv
// accelerator_pkg
//   Shared definitions for the accelerator datapath and its output serializer:
//   default array geometry (CORES, UNITS, WORD_WIDTH_ACC), the serializer state
//   enum, and a $clog2 helper that never returns a zero width.
package accelerator_pkg;

    localparam int CORES_DEFAULT          = 2;
    localparam int UNITS_DEFAULT          = 4;
    localparam int WORD_WIDTH_ACC_DEFAULT = 32;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } ser_state_t;

    // Counter width for n states; a one-state counter still gets one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
//   Generic one-entry AXI-Stream register slice. Upstream ready is a flop
//   (~skid_full of the next cycle), so no combinational path runs from
//   i_m_ready to o_s_ready. Data passes straight through when the skid is empty,
//   so it adds no latency.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_s_data/last/valid   upstream beat; o_s_ready upstream ready
//   o_m_data/last/valid   downstream beat; i_m_ready downstream ready
module axis_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_last,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [DATA_W-1:0] o_m_data,
    output logic              o_m_last,
    output logic              o_m_valid,
    input  logic              i_m_ready
);

    logic              r_full;
    logic              r_ready;
    logic              r_last;
    logic [DATA_W-1:0] r_data;
    logic              w_s_hs;
    logic              w_full_next;

    assign w_s_hs    = i_s_valid & r_ready;
    assign o_s_ready = r_ready;
    assign o_m_valid = r_full | w_s_hs;
    assign o_m_data  = r_full ? r_data : i_s_data;
    assign o_m_last  = r_full ? r_last : i_s_last;

    // A full skid drains when downstream takes it; an empty skid fills only
    // when a beat arrives that downstream cannot take this cycle.
    assign w_full_next = r_full ? ~i_m_ready : (w_s_hs & ~i_m_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_full  <= w_full_next;
            r_ready <= ~w_full_next;
            if (w_s_hs & ~r_full & ~i_m_ready) begin
                r_data <= i_s_data;
                r_last <= i_s_last;
            end
        end
    end

endmodule

// File: rtl/axis_output_serializer.sv
// axis_output_serializer
//   Splits each wide accelerator result beat (CORES*UNITS words) into SUB
//   consecutive M_DATA_WIDTH beats for the S2MM DMA, lowest word first, keeping
//   packet boundaries (tlast only on the final sub-beat of a tlast input beat).
// Optional build macro:
//   AXIS_OUTPUT_SERIALIZER_SKID_EN  put a one-entry skid slice in front of the
//                                   holding register (registered s_axis_tready)
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/   wide input stream; tuser is not forwarded
//   tlast/tuser
//   m_axis_tdata/tkeep/tvalid/    narrow output stream to the DMA
//   tready/tlast
module axis_output_serializer
    import accelerator_pkg::*;
#(
    parameter int CORES          = CORES_DEFAULT,
    parameter int UNITS          = UNITS_DEFAULT,
    parameter int WORD_WIDTH_ACC = WORD_WIDTH_ACC_DEFAULT,
    parameter int M_DATA_WIDTH   = 64,
    parameter int TUSER_WIDTH    = 7
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic [CORES*UNITS*WORD_WIDTH_ACC-1:0] s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic                                  s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0]                s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast
);

    localparam int S_W   = CORES * UNITS * WORD_WIDTH_ACC;
    localparam int WPB   = M_DATA_WIDTH / WORD_WIDTH_ACC;
    localparam int SUB   = (CORES * UNITS) / WPB;
    localparam int SUB_W = clog2_min1(SUB);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB - 1);

    ser_state_t       r_state;
    logic [SUB_W-1:0] r_sub;
    logic [S_W-1:0]   r_hold;
    logic             r_hold_last;

    logic             w_last_sub;
    logic             w_m_valid;
    logic             w_out_hs;
    logic             w_ld_ready;
    logic             w_ld_valid;
    logic             w_ld_last;
    logic [S_W-1:0]   w_ld_data;
    logic             w_unused;

    assign w_unused   = ^s_axis_tuser;

    assign w_last_sub = (r_sub == SUB_LAST);
    assign w_m_valid  = (r_state == SEND);
    assign w_out_hs   = w_m_valid & m_axis_tready;
    // The holding register can take a new beat when empty, or in the same
    // cycle its final sub-beat leaves (no bubble between input beats).
    assign w_ld_ready = (r_state == EMPTY) | (m_axis_tready & w_last_sub);

`ifdef AXIS_OUTPUT_SERIALIZER_SKID_EN
    axis_skid_buffer #(
        .DATA_W (S_W)
    ) u_skid (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_s_data  (s_axis_tdata),
        .i_s_last  (s_axis_tlast),
        .i_s_valid (s_axis_tvalid),
        .o_s_ready (s_axis_tready),
        .o_m_data  (w_ld_data),
        .o_m_last  (w_ld_last),
        .o_m_valid (w_ld_valid),
        .i_m_ready (w_ld_ready)
    );
`else
    assign w_ld_data     = s_axis_tdata;
    assign w_ld_last     = s_axis_tlast;
    assign w_ld_valid    = s_axis_tvalid;
    assign s_axis_tready = w_ld_ready & ~areset;
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= EMPTY;
            r_sub       <= '0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
        end else if (w_ld_valid & w_ld_ready) begin
            r_state     <= SEND;
            r_sub       <= '0;
            r_hold      <= w_ld_data;
            r_hold_last <= w_ld_last;
        end else if (w_out_hs) begin
            if (!w_last_sub) begin
                r_sub <= r_sub + SUB_W'(1);
            end else begin
                r_state <= EMPTY;
            end
        end
    end

    assign m_axis_tvalid = w_m_valid;
    assign m_axis_tdata  = r_hold[int'(r_sub) * M_DATA_WIDTH +: M_DATA_WIDTH];
    assign m_axis_tkeep  = {(M_DATA_WIDTH/8){w_m_valid}};
    assign m_axis_tlast  = w_m_valid & r_hold_last & w_last_sub;

endmodule

// File: doc/axis_output_serializer.md
# axis_output_serializer

Narrows the accelerator's wide result stream to DMA width: each input beat carries CORES×UNITS accumulator words, and the block emits them as consecutive narrower beats. It preserves packet boundaries, in the order the host reads them back (core-major, unit-minor). It sits between the accelerator output (LReLU/maxpool tail) and the S2MM DMA channel, and is the hardware consumer of the accelerator's output AXI-Stream.

## Interface
- CORES, 2, MEMBERS×COPIES×GROUPS cores per input beat
- UNITS, 4, rows per core per input beat
- WORD_WIDTH_ACC, 32, bits per output word
- M_DATA_WIDTH, 64, DMA data width; a multiple of WORD_WIDTH_ACC that divides CORES×UNITS×WORD_WIDTH_ACC
- TUSER_WIDTH, 7, input tuser width; tuser is not forwarded
- aclk  in  1  clock, all logic on its rising edge
- areset  in  1  synchronous, active-high reset
- s_axis_tdata  in  CORES×UNITS×WORD_WIDTH_ACC  word k=r×UNITS+u at bits [k×W +: W]
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of output packet
- s_axis_tuser  in  TUSER_WIDTH  ignored, except sampled for protocol checks in the bench
- m_axis_tdata  out  M_DATA_WIDTH  WPB=M_DATA_WIDTH/W words, lowest index in LSBs
- m_axis_tkeep  out  M_DATA_WIDTH/8  all ones while valid
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  DMA ready
- m_axis_tlast  out  1  last sub-beat of last input beat

## Operation
- SUB = CORES×UNITS/WPB sub-beats per input beat; sub_cnt is $clog2(SUB) bits wide (minimum 1).
- States:
  - EMPTY: no beat held; s_axis_tready=1.
  - SEND: holding register `hold` valid; m_axis_tvalid=1.
- Input handshake (s_tvalid&s_tready): hold←s_tdata, hold_last←s_tlast, sub_cnt←0, state→SEND.
- Output handshake (m_tvalid&m_tready):
  - If sub_cnt<SUB-1: sub_cnt+1.
  - Otherwise: go to EMPTY, unless an input handshake occurs in the same cycle. In that case reload and stay in SEND.
- s_axis_tready = (state==EMPTY) | (m_axis_tready & sub_cnt==SUB-1). This is the no-bubble path.
- m_axis_tdata = hold[sub_cnt×M_DATA_WIDTH +: M_DATA_WIDTH].
- m_axis_tlast = hold_last & (sub_cnt==SUB-1).
- No reordering, dropping or duplication. Packets are delimited only by s_axis_tlast.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, state=EMPTY, sub_cnt=0. s_axis_tready is forced 0 while areset=1.
- Latency: an input accepted at edge N gives m_axis_tvalid=1 after edge N, i.e. in cycle N+1.
- Throughput: one output beat per cycle while m_axis_tready=1. Sustained input rate is 1 beat per SUB cycles.
- m_axis_tvalid/tdata/tlast stay stable while m_axis_tvalid & ~m_axis_tready (AXI rule).
- Reset asserted mid-packet: the held beat is discarded, and m_axis_tvalid=0 from the next cycle.
- s_tlast on a beat with SUB=1: m_axis_tlast is asserted on that single output beat.

## Configuration
- AXIS_OUTPUT_SERIALIZER_SKID_EN
  - Defined:
    - A one-entry skid register sits in front of `hold`.
    - s_axis_tready is a flop, equal to ~skid_full.
    - An input arriving while hold is busy goes to skid, and moves to hold at the last sub-beat handshake.
    - This removes the m_axis_tready→s_axis_tready combinational path.
    - Latency stays 1 cycle, and skid data moves to hold with no bubble cycle.
  - Undefined: combinational tready as in Operation, with no skid storage.

## Structure
- Shared package accelerator_pkg holds:
  - the state enum (EMPTY, SEND);
  - defaults for CORES, UNITS and WORD_WIDTH_ACC, which are shared with the accelerator top.
- Sub-module axis_skid_buffer, a generic one-entry AXIS register slice, is instantiated only under AXIS_OUTPUT_SERIALIZER_SKID_EN.

## Test plan
All scenarios use defaults: SUB=4 and WPB=2.
- Single beat, words 0..7, tlast=1, m_tready=1 → outputs {1,0},{3,2},{5,4},{7,6} (high word, low word) in cycles 1–4. tlast only on the 4th beat. s_tready=0 in cycles 1–3.
- Back-to-back beats A and B, m_tready=1 → 8 consecutive output cycles with no gap. B is accepted in the same cycle as A's 4th sub-beat.
- m_tready toggled 1,0,0,1 during a beat → tdata and tlast held during stall cycles, no sub-beat skipped, and order preserved.
- Reset during sub_cnt=2 → m_tvalid=0 the next cycle. A new beat afterwards starts at word 0.
- Packet of 3 beats, tlast on beat 3 → exactly one m_tlast, on output beat 12.
- With SKID_EN, input held valid continuously and m_tready=0 for 10 cycles → s_tready drops after 2 accepted beats. Both beats are emitted intact once m_tready=1.
